fxp_mul_pipe: RTL and testbench

FXP_MUL_PIPE -- requirements
Module: fxp_mul_pipe

---
 rtl/fxp_mul_pipe.sv | 127 ++++++++++++
 tb/tb_fxp_mul_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier with round/saturate and a stall-all
// valid/ready pipeline: every stage freezes while the output is held.
module fxp_mul_pipe #(
  parameter int W      = 32,
  parameter int FRAC   = 28,
  parameter int STAGES = 3,
  parameter int ROUND  = 1,
  parameter int SAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int PW = 2 * W;
  localparam int RW = PW + 1;
  localparam logic [RW-1:0] RND_BIAS = (ROUND != 0) ? (RW'(1) << (FRAC - 1)) : '0;
  localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  logic                 advance;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] final_prod;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] r_full;
  logic [RW-W:0]        r_upper;
  logic                 ovf_c;
  logic [W-1:0]         result_c;
  logic [STAGES-1:0]    valid_reg;
  logic [W-1:0]         result_reg;
  logic                 ovf_reg;

  assign advance  = !(valid_reg[STAGES-1] && !out_ready);
  assign in_ready = advance;

  // Sign-extend first so the most negative operand squares exactly.
  assign a_ext  = {{W{a[W-1]}}, a};
  assign b_ext  = {{W{b[W-1]}}, b};
  assign prod_c = a_ext * b_ext;

  generate
    if (STAGES == 1) begin : g_single
      assign final_prod = prod_c;
    end else begin : g_multi
      logic signed [PW-1:0] prod_reg [STAGES-1];
      for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_prod
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              prod_reg[gi] <= '0;
            end else if (advance) begin
              prod_reg[gi] <= prod_c;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              prod_reg[gi] <= '0;
            end else if (advance) begin
              prod_reg[gi] <= prod_reg[gi-1];
            end
          end
        end
      end
      assign final_prod = prod_reg[STAGES-2];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_valid
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_reg[gi] <= 1'b0;
          end else if (advance) begin
            valid_reg[gi] <= in_valid;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_reg[gi] <= 1'b0;
          end else if (advance) begin
            valid_reg[gi] <= valid_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // One extra bit keeps the rounding bias from overflowing the product.
  assign biased  = {final_prod[PW-1], final_prod} + RND_BIAS;
  assign r_full  = biased >>> FRAC;
  assign r_upper = r_full[RW-1:W-1];
  assign ovf_c   = !((&r_upper) || !(|r_upper));

  always_comb begin
    result_c = r_full[W-1:0];
    if ((SAT != 0) && ovf_c) begin
      result_c = r_full[RW-1] ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else if (advance) begin
      result_reg <= result_c;
      ovf_reg    <= ovf_c;
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign result    = result_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Three multiplier variants (round+sat, round+wrap, floor+sat) driven in
// lockstep and checked against an exact wide-integer reference model.
module tb_fxp_mul_pipe;

  localparam int FRAC   = 28;
  localparam int STAGES = 3;
  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             has_exp;
    logic [2:0][31:0] exp_res;
    logic [2:0]       exp_ovf;
    logic [31:0]      acc_cyc;
  } pair_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] result_w    [3];
  logic        ovf_w       [3];

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [31:0] cyc = 0;
  logic        lat_chk = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_res [3];
  logic        prev_ovf [3];
  pair_t       q [$];
  pair_t       dir [5];
  pair_t       idle_p;

  fxp_mul_pipe #(.W(32), .FRAC(FRAC), .STAGES(STAGES), .ROUND(1), .SAT(1)) dut_rs (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .result(result_w[0]), .ovf(ovf_w[0]));

  fxp_mul_pipe #(.W(32), .FRAC(FRAC), .STAGES(STAGES), .ROUND(1), .SAT(0)) dut_rw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .result(result_w[1]), .ovf(ovf_w[1]));

  fxp_mul_pipe #(.W(32), .FRAC(FRAC), .STAGES(STAGES), .ROUND(0), .SAT(1)) dut_fs (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .result(result_w[2]), .ovf(ovf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Variant k: 0 = round/saturate, 1 = round/wrap, 2 = floor/saturate.
  function automatic logic [32:0] model(input logic [31:0] oa, input logic [31:0] ob, input int k);
    logic signed [127:0] sa, sb, p, r;
    logic                o;
    logic [31:0]         res;
    sa = {{96{oa[31]}}, oa};
    sb = {{96{ob[31]}}, ob};
    p  = sa * sb;
    if (k != 2) p = p + (128'sd1 <<< (FRAC - 1));
    r  = p >>> FRAC;
    o  = (r > MAXV) || (r < MINV);
    res = r[31:0];
    if (o && (k != 1)) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {o, res};
  endfunction

  function automatic pair_t mk(input logic [31:0] oa, input logic [31:0] ob, input logic [31:0] r0,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] ov);
    pair_t p;
    p = '0;
    p.a = oa;
    p.b = ob;
    p.has_exp = 1'b1;
    p.exp_res[0] = r0;
    p.exp_res[1] = r1;
    p.exp_res[2] = r2;
    p.exp_ovf = ov;
    return p;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'($urandom_range(0, 255)) - 32'd128;
      default: return $urandom;
    endcase
  endfunction

  function automatic pair_t rnd_pair();
    pair_t p;
    p = '0;
    p.a = rnd_word();
    p.b = rnd_word();
    return p;
  endfunction

  task automatic step(input logic iv, input pair_t e, input logic ordy);
    logic        exp_ir;
    pair_t       h;
    logic [32:0] m;
    @(negedge clk);
    cyc++;
    in_valid  = iv;
    a         = iv ? e.a : $urandom;
    b         = iv ? e.b : $urandom;
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("stall_hold_v%0d", k), 64'({out_valid_w[k], ovf_w[k], result_w[k]}),
              64'({1'b1, prev_ovf[k], prev_res[k]}));
      end
    end
    exp_ir = !(out_valid_w[0] && !ordy);
    check("in_ready", 64'(in_ready_w[0]), 64'(exp_ir));
    if (out_valid_w[0] && ordy) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_out", 64'(1), 64'(0));
      end else begin
        h = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          m = model(h.a, h.b, k);
          check($sformatf("res_v%0d", k), 64'(result_w[k]), 64'(m[31:0]));
          check($sformatf("ovf_v%0d", k), 64'(ovf_w[k]), 64'(m[32]));
          if (h.has_exp) begin
            check($sformatf("dir_res_v%0d", k), 64'(result_w[k]), 64'(h.exp_res[k]));
            check($sformatf("dir_ovf_v%0d", k), 64'(ovf_w[k]), 64'(h.exp_ovf[k]));
          end
        end
        if (lat_chk) check("latency", 64'(cyc - h.acc_cyc), 64'(STAGES));
        $display("out a=%h b=%h res=%h/%h/%h ovf=%b%b%b", h.a, h.b,
                 result_w[0], result_w[1], result_w[2], ovf_w[0], ovf_w[1], ovf_w[2]);
      end
    end
    if (iv && exp_ir) begin
      h = e;
      h.acc_cyc = cyc;
      q.push_back(h);
    end
    stalled_prev = out_valid_w[0] && !ordy;
    for (int k = 0; k < 3; k++) begin
      prev_res[k] = result_w[k];
      prev_ovf[k] = ovf_w[k];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    idle_p = '0;
    dir[0] = mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 3'b000);
    dir[1] = mk(32'hF000_0000, 32'h1800_0000, 32'hE800_0000, 32'hE800_0000, 32'hE800_0000, 3'b000);
    dir[2] = mk(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 3'b111);
    dir[3] = mk(32'h0000_0001, 32'h0800_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 3'b000);
    dir[4] = mk(32'hFFFF_FFFF, 32'h0800_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b000);

    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_v%0d", k), 64'(out_valid_w[k]), 64'(0));
      check($sformatf("rst_res_v%0d", k), 64'(result_w[k]), 64'(0));
      check($sformatf("rst_ovf_v%0d", k), 64'(ovf_w[k]), 64'(0));
      check($sformatf("rst_ready_v%0d", k), 64'(in_ready_w[k]), 64'(1));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Isolated directed pairs, then the same pairs back to back.
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, dir[i], 1'b1);
      repeat (5) step(1'b0, idle_p, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, dir[i], 1'b1);
    repeat (5) step(1'b0, idle_p, 1'b1);

    // Random stream with random backpressure.
    lat_chk = 1'b0;
    for (int i = 0; i < 250; i++) begin
      step($urandom_range(0, 3) != 0, rnd_pair(), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, idle_p, 1'b1);
    check("drain_empty", 64'(q.size()), 64'(0));

    // Reset mid-pipeline discards in-flight pairs.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, rnd_pair(), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_rst_valid_v%0d", k), 64'(out_valid_w[k]), 64'(0));
      check($sformatf("mid_rst_res_v%0d", k), 64'(result_w[k]), 64'(0));
      check($sformatf("mid_rst_ovf_v%0d", k), 64'(ovf_w[k]), 64'(0));
      check($sformatf("mid_rst_ready_v%0d", k), 64'(in_ready_w[k]), 64'(1));
    end
    q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    n_out = 0;
    step(1'b1, dir[1], 1'b1);
    repeat (6) step(1'b0, idle_p, 1'b1);
    check("post_rst_outputs", 64'(n_out), 64'(1));
    check("post_rst_empty", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
